// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch FSM encoding, instruction field positions.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'b001001;
  localparam logic [OP_W-1:0] OP_LWI   = 6'b001010;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam int unsigned FSM_W = 2;
  localparam logic [FSM_W-1:0] RESET_ST = 2'd0;
  localparam logic [FSM_W-1:0] FETCH    = 2'd1;
  localparam logic [FSM_W-1:0] HOLD     = 2'd2;
  localparam logic [FSM_W-1:0] RESOLVE  = 2'd3;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned TARGET_MSB = 25;
  localparam int unsigned TARGET_LSB = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection from the datapath's branch/jump/zero outcome (combinational).
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  output logic [PC_W-1:0]    next_pc
);

  logic [PC_W-1:0]   w_pc4;
  logic [PC_W-1:0]   w_jump_tgt;
  logic [PC_W-1:0]   w_br_off;
  logic signed [17:0] w_off18;
  logic              w_unused;

  assign w_pc4    = pc + PC_W'(4);
  assign w_off18  = {instr[IMM_MSB:IMM_LSB], 2'b00};
  // Signed source, so the size cast sign-extends (or truncates for narrow PCs).
  assign w_br_off = PC_W'(w_off18);
  // Opcode bits are decoded elsewhere.
  assign w_unused = ^instr[OPCODE_MSB:OPCODE_LSB];

  // Jump target keeps pc4's upper bits only when the PC is wider than the 28-bit target.
  if (PC_W <= 28) begin : g_jmp_short
    assign w_jump_tgt = PC_W'({instr[TARGET_MSB:TARGET_LSB], 2'b00});
  end else begin : g_jmp_long
    assign w_jump_tgt = {w_pc4[PC_W-1:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
  end

  // Jump wins over a taken branch; otherwise fall through to pc4.
  always_comb begin
    next_pc = w_pc4;
    if (jump) begin
      next_pc = w_jump_tgt;
    end else if (branch && zero) begin
      next_pc = w_pc4 + w_br_off;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle byte-serial instruction fetch with PC redirect on datapath resolution.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [7:0]         mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    opcode,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  input  logic               resolve_valid,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero
);

  logic [FSM_W-1:0]   r_state;
  logic [FSM_W-1:0]   w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [1:0]         r_byte_idx;
  logic [1:0]         w_byte_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic               r_mem_req;
  logic [PC_W-1:0]    r_mem_addr;
  logic               r_instr_valid;
  logic [PC_W-1:0]    w_next_pc;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc      (r_pc),
    .instr   (r_instr),
    .branch  (branch),
    .jump    (jump),
    .zero    (zero),
    .next_pc (w_next_pc)
  );

  assign w_byte_nxt = r_byte_idx + 2'd1;

  // Next-state logic; inputs that do not belong to the current state are ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RESET_ST: w_state_nxt = FETCH;
      FETCH:    if (mem_ack && (r_byte_idx == 2'd3)) w_state_nxt = HOLD;
      HOLD:     if (instr_ready) w_state_nxt = RESOLVE;
      RESOLVE:  if (resolve_valid) w_state_nxt = FETCH;
      default:  w_state_nxt = RESET_ST;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_ST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs; reset discards any partial fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_byte_idx    <= 2'd0;
      r_instr       <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= RESET_PC;
      r_instr_valid <= 1'b0;
    end else begin
      r_mem_req     <= (w_state_nxt == FETCH);
      r_instr_valid <= (w_state_nxt == HOLD);
      case (r_state)
        FETCH: begin
          if (mem_ack) begin
            case (r_byte_idx)
              2'd0: r_instr[31:24] <= mem_rdata;
              2'd1: r_instr[23:16] <= mem_rdata;
              2'd2: r_instr[15:8]  <= mem_rdata;
              2'd3: r_instr[7:0]   <= mem_rdata;
            endcase
            r_byte_idx <= w_byte_nxt;
            r_mem_addr <= r_pc + PC_W'(w_byte_nxt);
          end
        end
        RESOLVE: begin
          if (resolve_valid) begin
            r_pc       <= w_next_pc;
            r_mem_addr <= w_next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_instr;
  assign opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: program walk, redirects, back-pressure, wait states, reset abort.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic        resolve_valid;
  logic        branch;
  logic        jump;
  logic        zero;

  logic [7:0]  mem [0:65535];
  logic [31:0] cyc;
  logic        ack_en;
  logic        gap_mode;
  logic        mon_en;
  logic        prev_req;
  logic        prev_ack;
  logic [15:0] prev_addr;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc            (pc),
    .resolve_valid (resolve_valid),
    .branch        (branch),
    .jump          (jump),
    .zero          (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  assign mem_ack   = ack_en & (~gap_mode | (cyc[1:0] == 2'b00));
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Address must hold while a request is waiting for its ack.
  always @(negedge clk) begin
    if (mon_en && prev_req && mem_req && !prev_ack)
      chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [15:0] a, input logic [31:0] w);
    mem[a]         = w[31:24];
    mem[a + 16'd1] = w[23:16];
    mem[a + 16'd2] = w[15:8];
    mem[a + 16'd3] = w[7:0];
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic do_instr(input string tag, input logic [15:0] e_pc, input logic [31:0] e_instr,
                          input logic br, input logic jp, input logic zr, input logic [15:0] e_next);
    logic [5:0] e_op;
    e_op = e_instr[31:26];
    wait_valid(tag);
    chk({tag, "_instr"}, instr, e_instr);
    chk({tag, "_opcode"}, 32'(opcode), 32'(e_op));
    chk({tag, "_pc"}, 32'(pc), 32'(e_pc));
    chk({tag, "_req_hold"}, 32'(mem_req), 32'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(instr_valid), 32'd0);
    branch = br; jump = jp; zero = zr;
    resolve_valid = 1'b1;
    step();
    resolve_valid = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    chk({tag, "_next_addr"}, 32'(mem_addr), 32'(e_next));
    chk({tag, "_next_req"}, 32'(mem_req), 32'd1);
  endtask

  // Releases reset and checks the 5-cycle path to the first valid word.
  task automatic release_and_check(input string tag);
    int n;
    rst = 1'b0;
    step();
    chk({tag, "_req_rise"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr0"}, 32'(mem_addr), 32'h0000);
    n = 1;
    while (instr_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd5);
  endtask

  initial begin
    int n;
    cyc = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    put_word(16'h0000, 32'h8C220005);
    put_word(16'h0004, 32'h08000004);
    put_word(16'h0008, 32'hA1B2C3D4);
    put_word(16'h000C, 32'h11223344);
    put_word(16'h0010, 32'h10000003);
    put_word(16'h0014, 32'h08000004);
    put_word(16'h001C, 32'h08000040);
    put_word(16'h0020, 32'h1000FFFE);
    put_word(16'h0100, 32'h08003FFF);
    put_word(16'hFFFC, 32'h2C000000);

    rst = 1'b1; ack_en = 1'b1; gap_mode = 1'b0; mon_en = 1'b0;
    instr_ready = 1'b0; resolve_valid = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0;
    repeat (3) step();

    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0000);

    release_and_check("boot");
    do_instr("lw_seq",   16'h0000, 32'h8C220005, 1'b0, 1'b0, 1'b0, 16'h0004);
    do_instr("j_10",     16'h0004, 32'h08000004, 1'b0, 1'b1, 1'b0, 16'h0010);
    do_instr("beq_nt",   16'h0010, 32'h10000003, 1'b1, 1'b0, 1'b0, 16'h0014);
    do_instr("j_back",   16'h0014, 32'h08000004, 1'b0, 1'b1, 1'b0, 16'h0010);
    do_instr("beq_tk",   16'h0010, 32'h10000003, 1'b1, 1'b0, 1'b1, 16'h0020);
    do_instr("beq_neg",  16'h0020, 32'h1000FFFE, 1'b1, 1'b0, 1'b1, 16'h001C);
    do_instr("j_and_br", 16'h001C, 32'h08000040, 1'b1, 1'b1, 1'b1, 16'h0100);
    do_instr("j_top",    16'h0100, 32'h08003FFF, 1'b0, 1'b1, 1'b0, 16'hFFFC);
    do_instr("wrap",     16'hFFFC, 32'h2C000000, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Back-pressure: decode stalls 5 cycles, word and pc must hold.
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_instr", instr, 32'h8C220005);
      chk("bp_pc", 32'(pc), 32'h0000);
    end

    // Zero-wait decode and resolve: six cycles per instruction.
    instr_ready = 1'b1; resolve_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (instr_valid !== 1'b1 && n < 30);
    instr_ready = 1'b0; resolve_valid = 1'b0;
    chk("tput_cycles", 32'(n), 32'd6);
    chk("tput_instr", instr, 32'h08000004);
    chk("tput_pc", 32'(pc), 32'h0004);

    // Wait states on the memory port.
    gap_mode = 1'b1; mon_en = 1'b1;
    do_instr("gap_a", 16'h0004, 32'h08000004, 1'b0, 1'b0, 1'b0, 16'h0008);
    do_instr("gap_b", 16'h0008, 32'hA1B2C3D4, 1'b0, 1'b0, 1'b0, 16'h000C);
    gap_mode = 1'b0; mon_en = 1'b0;

    // Reset after two bytes of the 0x000C fetch; ack stays high through reset.
    step();
    step();
    chk("abort_addr", 32'(mem_addr), 32'h000E);
    rst = 1'b1;
    step();
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_addr_rst", 32'(mem_addr), 32'h0000);
    chk("abort_instr", instr, 32'h0);
    chk("abort_pc", 32'(pc), 32'h0000);
    step();
    chk("abort_valid", 32'(instr_valid), 32'd0);
    release_and_check("refetch");
    chk("refetch_instr", instr, 32'h8C220005);
    chk("refetch_pc", 32'(pc), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch unit for the 8-bit microprocessor.
- Reads 32-bit instruction words one byte at a time over the 8-bit instruction-memory port and presents the assembled word to decode.
- Exposes the 6-bit opcode field directly to the control unit.
- Holds the program counter and redirects it using the branch/jump/zero resolution returned by the datapath for each issued instruction.

## Interface
Parameters:
- PC_W, 16, program-counter and byte-address width; all PC arithmetic is modulo 2^PC_W.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_req  out  1  byte read request; held high until acknowledged.
- mem_addr  out  PC_W  byte address, stable while mem_req high.
- mem_ack  in  1  read accepted; mem_rdata valid in this cycle.
- mem_rdata  in  8  read byte.
- instr  out  32  assembled instruction word.
- opcode  out  6  instr[31:26], for the control unit.
- instr_valid  out  1  instr/opcode/pc valid.
- instr_ready  in  1  decode accepts the instruction.
- pc  out  PC_W  address of the presented instruction.
- resolve_valid  in  1  datapath outcome for the accepted instruction.
- branch, jump, zero  in  1 each  control/ALU outcome, sampled with resolve_valid.

## Operation
FSM states: RESET_ST, FETCH, HOLD, RESOLVE.
- RESET_ST: entered while rst is high.
  - Clears pc to RESET_PC, byte_idx to 0, instr to 0.
  - Drives mem_req=0 and instr_valid=0.
  - Goes to FETCH on the first cycle with rst low.
- FETCH:
  - Drives mem_req=1 and mem_addr = pc + byte_idx (mod 2^PC_W).
  - On mem_ack, stores mem_rdata into instr byte lane (3 − byte_idx), big-endian, so byte 0 is bits [31:24].
  - byte_idx 0→3; the ack for byte_idx=3 moves the FSM to HOLD and resets byte_idx to 0.
- HOLD:
  - Drives instr_valid=1; instr, opcode and pc stay stable.
  - Moves to RESOLVE on instr_valid && instr_ready.
- RESOLVE:
  - Waits for resolve_valid, then loads next PC and returns to FETCH.
  - pc4 = pc + 4.
  - Next PC when jump=1: {pc4[PC_W-1:28 clipped], instr[25:0], 2'b00} truncated to PC_W. For PC_W ≤ 28 this is simply (instr[25:0] << 2) truncated.
  - Next PC when jump=0, branch=1, zero=1: pc4 + (sign-extended instr[15:0] << 2).
  - Next PC otherwise: pc4.
  - jump has priority when jump and branch are both set.

Boundary rules:
- mem_ack outside FETCH is ignored.
- resolve_valid outside RESOLVE is ignored.
- instr_ready outside HOLD is ignored.
- PC and byte addresses wrap silently at 2^PC_W; a fetch that starts at 2^PC_W − 2 reads bytes FFFE, FFFF, 0000, 0001 (PC_W=16).
- rst in any state, including mid-fetch with mem_req high, aborts within that cycle. Partially assembled bytes are discarded, and a late mem_ack is ignored.
- Unknown opcodes are fetched and presented unchanged; decoding them is not this block's concern.

## Timing
- All outputs are registered.
- Reset values: mem_req=0, mem_addr=RESET_PC, instr=0, opcode=0, instr_valid=0, pc=RESET_PC.
- mem_req rises on the first cycle after rst is low.
- Each byte completes on the cycle mem_ack is high; the next byte's mem_addr is presented the following cycle.
- With mem_ack tied high, the minimum fetch is 4 cycles, and instr_valid rises 1 cycle after the 4th ack.
- With zero-wait decode and resolve (instr_ready and resolve_valid high), throughput is one instruction per 6 cycles.
- Next PC is visible on mem_addr the cycle after resolve_valid.

## Structure
Shared package cpu_pkg holds:
- Opcode constants: OP_RTYPE=6'b000000, OP_J=6'b000010, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_SUBI=6'b001001, OP_LWI=6'b001010, OP_LW=6'b100011, OP_SW=6'b101011.
- The fetch state encoding.
- The instruction field bit positions (opcode [31:26], target [25:0], imm [15:0]).

Sub-module next_pc_calc: purely combinational. Inputs are pc, instr, branch, jump, zero; output is next_pc.

## Test plan
- Reset, mem_ack always 1, memory at bytes 0–3 = 8C,22,00,05 → instr_valid rises on cycle 5 with instr=0x8C220005, opcode=6'b100011, pc=0x0000.
- Sequential: resolve with branch=0, jump=0 → next mem_addr=0x0004; fetched instr matches bytes 4–7.
- BEQ taken: pc=0x0010, instr=0x10000003, resolve branch=1, zero=1 → next fetch at 0x0020. Same with zero=0 → 0x0014.
- Negative branch: pc=0x0020, imm=0xFFFE, taken → next fetch at 0x001C. Jump instr=0x08000040 → 0x0100. jump=1 and branch=1 together → jump target.
- Back-pressure and wait states: instr_ready low for 5 cycles keeps instr/pc stable. Random mem_ack gaps leave mem_addr stable while mem_req is high.
- Edge cases, with PC_W=16:
  - rst asserted after 2 bytes fetched → mem_req=0 the next cycle; the refetch starts at RESET_PC with all 4 bytes.
  - Wrap: pc=0xFFFC sequential → next pc=0x0000.
